control_sequencer: RTL and testbench
====================================

# control_sequencer

Fetch/decode/execute controller directly upstream of the 4-bit accumulator datapath. It fetches 8-bit instructions from an external asynchronous program ROM through a 12-bit program counter and latches the opcode and operand. During the execute phase it drives the datapath's input-buffer, output-buffer and accumulator enables, the 3-bit ALU function code and the 4-bit immediate bus. It latches the datapath's C/Z flags and resolves conditional jumps against them.

## Interface
Parameters:
- none (widths fixed: PC 12, instruction 8, data 4)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- run  in  1  1 = advance; 0 = freeze all state and force control outputs low
- program_byte  in  8  ROM data at address pc; combinationally valid in the same cycle
- c_in  in  1  datapath carry flag for the current ALU result
- z_in  in  1  datapath zero flag for the current ALU result
- pc  out  12  program ROM address (registered)
- instr  out  4  latched opcode (program_byte[7:4])
- oprnd  out  4  latched operand (program_byte[3:0]); drives datapath busInput
- phase  out  1  0 in FETCH/FETCH_ADDR/HALT, 1 in EXEC
- flags  out  2  registered {C,Z}
- enBuff1  out  1  datapath input-buffer enable
- enBuff2  out  1  datapath output-buffer enable
- enAccu  out  1  accumulator load enable
- F  out  3  ALU function code
- halted  out  1  1 while in HALT

## Operation
- States: FETCH, FETCH_ADDR, EXEC, HALT.
- FETCH: latch {instr, oprnd} from program_byte, increment pc.
  - If the opcode is 0x8–0xC, go to FETCH_ADDR; otherwise go to EXEC.
- FETCH_ADDR: latch program_byte into the 8-bit addr_lo register, increment pc, go to EXEC.
- EXEC: perform the instruction, then go to FETCH. For opcode 0xF, go to HALT instead.
- HALT: hold all state until reset; run is ignored.
- ALU encoding driven on F: 000 pass A, 001 A−B, 010 pass B, 011 A+B, 100 NAND.
- Opcode effects in EXEC (unlisted enables are 0; F = 000 when not listed):
  - 0x0 NOP: no effect.
  - 0x1 LIT: enBuff1, F=010, enAccu.
  - 0x2 ADDI: enBuff1, F=011, enAccu.
  - 0x3 SUBI: enBuff1, F=001, enAccu.
  - 0x4 NANDI: enBuff1, F=100, enAccu.
  - 0x5 CMPI: enBuff1, F=001, no enAccu.
  - 0x6 OUT: enBuff2, F=000.
  - 0x8 JMP: always taken.
  - 0x9 JC: taken if C=1.
  - 0xA JNC: taken if C=0.
  - 0xB JZ: taken if Z=1.
  - 0xC JNZ: taken if Z=0.
  - 0x7, 0xD, 0xE: treated as NOP.
  - 0xF HLT: enter HALT.
- Jumps: when taken, pc <= {oprnd, addr_lo} at the end of EXEC. When not taken, pc is unchanged and already points past the 2-byte instruction.
- Jump conditions use the registered flags, never c_in/z_in.
- Flags: at the end of EXEC for opcodes 0x1–0x5 only, flags <= {c_in, z_in}. All other opcodes leave flags unchanged.
- pc increments modulo 4096 (0xFFF → 0x000, no error).
- Control outputs (enBuff1, enBuff2, enAccu, F) are decoded from state and instr. They are nonzero only in EXEC with run=1.

## Timing
- Reset values:
  - State: FETCH.
  - pc = 0x000, instr = 0, oprnd = 0, addr_lo = 0x00, flags = 00.
  - phase = 0, halted = 0; enables = 0, F = 000.
- Reset has priority over run and over HALT.
- Reset asserted mid-instruction aborts the instruction: no accumulator write and no flag update occur in that cycle.
- Latency per instruction:
  - 1-byte instruction: 2 cycles (FETCH, EXEC).
  - Jump: 3 cycles (FETCH, FETCH_ADDR, EXEC).
- The datapath accumulator loads on the clock edge ending EXEC, the same edge on which flags latch.
- run=0: no register changes, outputs held except control enables/F forced to 0. On run returning to 1, execution resumes in the same state.
- HLT: halted rises on the edge ending EXEC. pc then points to the byte after HLT.

## Test plan
- Reset, then program {0x13, 0x24, 0x60, 0xF0} with run=1:
  - In EXEC of LIT: enBuff1=1, F=010, enAccu=1, oprnd=3.
  - After ADDI: EXEC shows F=011, oprnd=4.
  - OUT EXEC: enBuff2=1, enAccu=0.
  - halted=1 at cycle 8; pc=0x004.
- JZ with flags Z=1, bytes {0xB1, 0x23}: 3 cycles, then pc=0x123. Repeat with Z=0: pc = start+2.
- CMPI with c_in=0, z_in=1 at EXEC: flags → 01, enAccu=0. Following NOP leaves flags at 01.
- Place JMP 0x000 at address 0xFFE/0xFFF: after fetch pc wraps to 0x000 and the jump lands at 0x000. Also run a NOP at 0xFFF: pc wraps to 0x000.
- Deassert run for 3 cycles during EXEC of ADDI: pc/state frozen and enables 0 throughout. Re-enable: ADDI completes with enAccu=1 for exactly one cycle.
- Assert reset in FETCH_ADDR and again in HALT: next cycle pc=0x000, state FETCH, flags=00, halted=0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
// Fetch/decode/execute controller for the 4-bit accumulator datapath.
// It fetches 1- or 2-byte instructions from an asynchronous program ROM,
// drives the datapath enables and ALU function code during EXEC, holds the
// registered {C,Z} flags and resolves conditional jumps against them.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  program_byte,
    input  logic        c_in,
    input  logic        z_in,
    output logic [11:0] pc,
    output logic [3:0]  instr,
    output logic [3:0]  oprnd,
    output logic        phase,
    output logic [1:0]  flags,
    output logic        enBuff1,
    output logic        enBuff2,
    output logic        enAccu,
    output logic [2:0]  F,
    output logic        halted
);

    // Sequencer states
    localparam logic [1:0] ST_FETCH      = 2'd0;
    localparam logic [1:0] ST_FETCH_ADDR = 2'd1;
    localparam logic [1:0] ST_EXEC       = 2'd2;
    localparam logic [1:0] ST_HALT       = 2'd3;

    // Opcodes
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LIT   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_SUBI  = 4'h3;
    localparam logic [3:0] OP_NANDI = 4'h4;
    localparam logic [3:0] OP_CMPI  = 4'h5;
    localparam logic [3:0] OP_OUT   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JC    = 4'h9;
    localparam logic [3:0] OP_JNC   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JNZ   = 4'hC;
    localparam logic [3:0] OP_HLT   = 4'hF;

    // ALU function codes
    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_PASS_B = 3'b010;
    localparam logic [2:0] ALU_ADD    = 3'b011;
    localparam logic [2:0] ALU_NAND   = 3'b100;

    // Control word {enBuff1, enBuff2, enAccu, F[2:0]} for an opcode in EXEC.
    function automatic logic [5:0] decode_ctrl(input logic [3:0] op);
        logic [5:0] w;
        case (op)
            OP_LIT:   w = {1'b1, 1'b0, 1'b1, ALU_PASS_B};
            OP_ADDI:  w = {1'b1, 1'b0, 1'b1, ALU_ADD};
            OP_SUBI:  w = {1'b1, 1'b0, 1'b1, ALU_SUB};
            OP_NANDI: w = {1'b1, 1'b0, 1'b1, ALU_NAND};
            OP_CMPI:  w = {1'b1, 1'b0, 1'b0, ALU_SUB};
            OP_OUT:   w = {1'b0, 1'b1, 1'b0, ALU_PASS_A};
            default:  w = {1'b0, 1'b0, 1'b0, ALU_PASS_A};
        endcase
        return w;
    endfunction

    // Two-byte instructions carry the low address byte after the opcode byte.
    function automatic logic is_jump(input logic [3:0] op);
        logic j;
        case (op)
            OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ: j = 1'b1;
            default:                              j = 1'b0;
        endcase
        return j;
    endfunction

    // Only the ALU-writing immediates latch the datapath flags.
    function automatic logic updates_flags(input logic [3:0] op);
        logic u;
        case (op)
            OP_LIT, OP_ADDI, OP_SUBI, OP_NANDI, OP_CMPI: u = 1'b1;
            default:                                     u = 1'b0;
        endcase
        return u;
    endfunction

    // Branch resolution against the registered {C,Z} flags.
    function automatic logic jump_taken(input logic [3:0] op, input logic [1:0] fl);
        logic t;
        case (op)
            OP_JMP:  t = 1'b1;
            OP_JC:   t = fl[1];
            OP_JNC:  t = ~fl[1];
            OP_JZ:   t = fl[0];
            OP_JNZ:  t = ~fl[0];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic [1:0]  state_r, state_s;
    logic [11:0] pc_r, pc_s;
    logic [3:0]  instr_r, instr_s;
    logic [3:0]  oprnd_r, oprnd_s;
    logic [7:0]  addr_lo_r, addr_lo_s;
    logic [1:0]  flags_r, flags_s;
    logic        phase_r;
    logic        halted_r;
    logic [5:0]  ctrl_s;

    // Next-state and datapath-register update logic; run=0 holds everything.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        instr_s   = instr_r;
        oprnd_s   = oprnd_r;
        addr_lo_s = addr_lo_r;
        flags_s   = flags_r;
        if (state_r == ST_HALT) begin
            state_s = ST_HALT;
        end else if (run) begin
            case (state_r)
                ST_FETCH: begin
                    instr_s = program_byte[7:4];
                    oprnd_s = program_byte[3:0];
                    pc_s    = pc_r + 12'd1;
                    if (is_jump(program_byte[7:4])) begin
                        state_s = ST_FETCH_ADDR;
                    end else begin
                        state_s = ST_EXEC;
                    end
                end
                ST_FETCH_ADDR: begin
                    addr_lo_s = program_byte;
                    pc_s      = pc_r + 12'd1;
                    state_s   = ST_EXEC;
                end
                ST_EXEC: begin
                    if (instr_r == OP_HLT) begin
                        state_s = ST_HALT;
                    end else begin
                        state_s = ST_FETCH;
                    end
                    if (is_jump(instr_r) && jump_taken(instr_r, flags_r)) begin
                        pc_s = {oprnd_r, addr_lo_r};
                    end else begin
                        pc_s = pc_r;
                    end
                    if (updates_flags(instr_r)) begin
                        flags_s = {c_in, z_in};
                    end else begin
                        flags_s = flags_r;
                    end
                end
                default: begin
                    state_s = ST_FETCH;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State registers with synchronous reset taking priority over run and HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_FETCH;
            pc_r      <= 12'h000;
            instr_r   <= 4'h0;
            oprnd_r   <= 4'h0;
            addr_lo_r <= 8'h00;
            flags_r   <= 2'b00;
            phase_r   <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            instr_r   <= instr_s;
            oprnd_r   <= oprnd_s;
            addr_lo_r <= addr_lo_s;
            flags_r   <= flags_s;
            phase_r   <= (state_s == ST_EXEC);
            halted_r  <= (state_s == ST_HALT);
        end
    end

    // Datapath controls: live only in EXEC while running and not being reset,
    // so a stalled or aborted instruction never loads the accumulator.
    always_comb begin
        if (run && !reset && (state_r == ST_EXEC)) begin
            ctrl_s = decode_ctrl(instr_r);
        end else begin
            ctrl_s = 6'b000000;
        end
    end

    assign pc     = pc_r;
    assign instr  = instr_r;
    assign oprnd  = oprnd_r;
    assign flags  = flags_r;
    assign phase  = phase_r;
    assign halted = halted_r;
    assign {enBuff1, enBuff2, enAccu, F} = ctrl_s;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a ROM model feeds program_byte,
// each test pushes its expected per-cycle observations into a scoreboard and
// then pops and compares one entry per clock.
module tb_control_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [7:0]  program_byte;
    logic        c_in;
    logic        z_in;
    logic [11:0] pc;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        phase;
    logic [1:0]  flags;
    logic        enBuff1;
    logic        enBuff2;
    logic        enAccu;
    logic [2:0]  F;
    logic        halted;

    logic [7:0]  rom [0:4095];
    logic [29:0] sb [$];
    logic [29:0] got_v;
    logic [29:0] exp_v;
    int          errors;
    int          checks;

    // {enBuff1, enBuff2, enAccu, F}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LIT  = 6'b101010;
    localparam logic [5:0] C_ADDI = 6'b101011;
    localparam logic [5:0] C_CMPI = 6'b100001;
    localparam logic [5:0] C_OUT  = 6'b010000;

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .program_byte(program_byte),
        .c_in(c_in), .z_in(z_in), .pc(pc), .instr(instr), .oprnd(oprnd),
        .phase(phase), .flags(flags), .enBuff1(enBuff1), .enBuff2(enBuff2),
        .enAccu(enAccu), .F(F), .halted(halted)
    );

    assign program_byte = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] snap();
        return {pc, instr, oprnd, phase, flags, enBuff1, enBuff2, enAccu, F, halted};
    endfunction

    task automatic push(input logic [11:0] p, input logic [3:0] i, input logic [3:0] o,
                        input logic ph, input logic [1:0] fl, input logic [5:0] ct,
                        input logic h);
        sb.push_back({p, i, o, ph, fl, ct, h});
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b1;
        c_in  = 1'b1;
        z_in  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        #1;
        got_v = snap();
        exp_v = sb.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", got_v, exp_v);
        end
        reset = 1'b0;
    endtask

    task automatic test_program();
        int n;
        clear_rom();
        rom[0] = 8'h13; rom[1] = 8'h24; rom[2] = 8'h60; rom[3] = 8'hF0;
        c_in = 1'b1; z_in = 1'b0;
        do_reset();
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h001, 4'h1, 4'h3, 1'b1, 2'b00, C_LIT,  1'b0);
        push(12'h001, 4'h1, 4'h3, 1'b0, 2'b10, C_NONE, 1'b0);
        push(12'h002, 4'h2, 4'h4, 1'b1, 2'b10, C_ADDI, 1'b0);
        push(12'h002, 4'h2, 4'h4, 1'b0, 2'b10, C_NONE, 1'b0);
        push(12'h003, 4'h6, 4'h0, 1'b1, 2'b10, C_OUT,  1'b0);
        push(12'h003, 4'h6, 4'h0, 1'b0, 2'b10, C_NONE, 1'b0);
        push(12'h004, 4'hF, 4'h0, 1'b1, 2'b10, C_NONE, 1'b0);
        push(12'h004, 4'hF, 4'h0, 1'b0, 2'b10, C_NONE, 1'b1);
        push(12'h004, 4'hF, 4'h0, 1'b0, 2'b10, C_NONE, 1'b1);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            #1;
            got_v = snap();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL program cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cmpi_jz();
        int n;
        clear_rom();
        rom[0] = 8'h55; rom[1] = 8'h00; rom[2] = 8'hB1; rom[3] = 8'h23;
        c_in = 1'b0; z_in = 1'b1;
        do_reset();
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h001, 4'h5, 4'h5, 1'b1, 2'b00, C_CMPI, 1'b0);
        push(12'h001, 4'h5, 4'h5, 1'b0, 2'b01, C_NONE, 1'b0);
        push(12'h002, 4'h0, 4'h0, 1'b1, 2'b01, C_NONE, 1'b0);
        push(12'h002, 4'h0, 4'h0, 1'b0, 2'b01, C_NONE, 1'b0);
        push(12'h003, 4'hB, 4'h1, 1'b0, 2'b01, C_NONE, 1'b0);
        push(12'h004, 4'hB, 4'h1, 1'b1, 2'b01, C_NONE, 1'b0);
        push(12'h123, 4'hB, 4'h1, 1'b0, 2'b01, C_NONE, 1'b0);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            if (c == 3) begin
                c_in = 1'b1;
                z_in = 1'b0;
            end
            #1;
            got_v = snap();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL cmpi_jz cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_not_taken();
        int n;
        clear_rom();
        rom[0] = 8'hB1; rom[1] = 8'h23; rom[2] = 8'hC4; rom[3] = 8'h56;
        c_in = 1'b1; z_in = 1'b1;
        do_reset();
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h001, 4'hB, 4'h1, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h002, 4'hB, 4'h1, 1'b1, 2'b00, C_NONE, 1'b0);
        push(12'h002, 4'hB, 4'h1, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h003, 4'hC, 4'h4, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h004, 4'hC, 4'h4, 1'b1, 2'b00, C_NONE, 1'b0);
        push(12'h456, 4'hC, 4'h4, 1'b0, 2'b00, C_NONE, 1'b0);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            #1;
            got_v = snap();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL jz_not_taken cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap_jmp();
        int n;
        clear_rom();
        rom[0] = 8'h8F; rom[1] = 8'hFE; rom[4094] = 8'h80; rom[4095] = 8'h00;
        c_in = 1'b0; z_in = 1'b0;
        do_reset();
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h001, 4'h8, 4'hF, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h002, 4'h8, 4'hF, 1'b1, 2'b00, C_NONE, 1'b0);
        push(12'hFFE, 4'h8, 4'hF, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'hFFF, 4'h8, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h000, 4'h8, 4'h0, 1'b1, 2'b00, C_NONE, 1'b0);
        push(12'h000, 4'h8, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            #1;
            got_v = snap();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL wrap_jmp cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap_nop();
        int n;
        clear_rom();
        rom[0] = 8'h8F; rom[1] = 8'hFF; rom[4095] = 8'h00;
        c_in = 1'b1; z_in = 1'b1;
        do_reset();
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h001, 4'h8, 4'hF, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h002, 4'h8, 4'hF, 1'b1, 2'b00, C_NONE, 1'b0);
        push(12'hFFF, 4'h8, 4'hF, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h000, 4'h0, 4'h0, 1'b1, 2'b00, C_NONE, 1'b0);
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            #1;
            got_v = snap();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL wrap_nop cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_run_freeze();
        int n;
        clear_rom();
        rom[0] = 8'h13; rom[1] = 8'h24;
        c_in = 1'b0; z_in = 1'b0;
        do_reset();
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h001, 4'h1, 4'h3, 1'b1, 2'b00, C_LIT,  1'b0);
        push(12'h001, 4'h1, 4'h3, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h002, 4'h2, 4'h4, 1'b1, 2'b00, C_NONE, 1'b0);
        push(12'h002, 4'h2, 4'h4, 1'b1, 2'b00, C_NONE, 1'b0);
        push(12'h002, 4'h2, 4'h4, 1'b1, 2'b00, C_NONE, 1'b0);
        push(12'h002, 4'h2, 4'h4, 1'b1, 2'b00, C_ADDI, 1'b0);
        push(12'h002, 4'h2, 4'h4, 1'b0, 2'b11, C_NONE, 1'b0);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            if (c == 3) begin
                run  = 1'b0;
                c_in = 1'b1;
                z_in = 1'b1;
            end
            if (c == 6) run = 1'b1;
            #1;
            got_v = snap();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL run_freeze cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_rom();
        rom[0] = 8'h55; rom[1] = 8'h80; rom[2] = 8'h05; rom[5] = 8'hF0;
        c_in = 1'b1; z_in = 1'b1;
        do_reset();
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h001, 4'h5, 4'h5, 1'b1, 2'b00, C_CMPI, 1'b0);
        push(12'h001, 4'h5, 4'h5, 1'b0, 2'b11, C_NONE, 1'b0);
        push(12'h002, 4'h8, 4'h0, 1'b0, 2'b11, C_NONE, 1'b0);
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h001, 4'h5, 4'h5, 1'b1, 2'b00, C_CMPI, 1'b0);
        push(12'h001, 4'h5, 4'h5, 1'b0, 2'b11, C_NONE, 1'b0);
        push(12'h002, 4'h8, 4'h0, 1'b0, 2'b11, C_NONE, 1'b0);
        push(12'h003, 4'h8, 4'h0, 1'b1, 2'b11, C_NONE, 1'b0);
        push(12'h005, 4'h8, 4'h0, 1'b0, 2'b11, C_NONE, 1'b0);
        push(12'h006, 4'hF, 4'h0, 1'b1, 2'b11, C_NONE, 1'b0);
        push(12'h006, 4'hF, 4'h0, 1'b0, 2'b11, C_NONE, 1'b1);
        push(12'h006, 4'hF, 4'h0, 1'b0, 2'b11, C_NONE, 1'b1);
        push(12'h006, 4'hF, 4'h0, 1'b0, 2'b11, C_NONE, 1'b1);
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        push(12'h001, 4'h5, 4'h5, 1'b1, 2'b00, C_NONE, 1'b0);
        push(12'h000, 4'h0, 4'h0, 1'b0, 2'b00, C_NONE, 1'b0);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            if (c == 3)  reset = 1'b1;
            if (c == 4)  reset = 1'b0;
            if (c == 12) run   = 1'b0;
            if (c == 13) reset = 1'b1;
            if (c == 14) begin
                reset = 1'b0;
                run   = 1'b1;
            end
            if (c == 15) reset = 1'b1;
            if (c == 16) reset = 1'b0;
            #1;
            got_v = snap();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        run    = 1'b1;
        c_in   = 1'b0;
        z_in   = 1'b0;
        clear_rom();
        test_reset();
        test_program();
        test_cmpi_jz();
        test_jump_not_taken();
        test_wrap_jmp();
        test_wrap_nop();
        test_run_freeze();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
